// File: rtl/mdio_pkg.sv
// Shared MDIO constants and FSM state encoding.
// The peripheral side of the link uses the same definitions.
package mdio_pkg;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int FRAME_BITS   = 32;
    localparam int READ_OE_BITS = 14;
    localparam int DATA_BITS    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_OUT = 2'd1,
        READ_IN   = 2'd2,
        DONE      = 2'd3
    } mdio_state_e;

endpackage

// File: rtl/mdio_controller.sv
// MDIO station-management controller: shifts a 32-bit frame out on MDIO with MDC = CLK/2,
// and for read frames releases the line after REGAD and captures 16 data bits from MDIO_IN.
module mdio_controller
    import mdio_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic        MDIO_DONE,
    output logic        DATA_RDY,
    output logic [15:0] RD_DATA,
    output mdio_state_e DBG_STATE
);

    // Handshake: MDIO_START is a single-cycle request, accepted only when the FSM
    // can take a new frame; MDIO_DONE is the one-cycle completion strobe.

    localparam logic [4:0] LAST_BIT      = 5'(FRAME_BITS - 1);
    localparam logic [4:0] LAST_DRIVEN_R = 5'(READ_OE_BITS - 1);
    localparam logic [4:0] FIRST_CAP_BIT = 5'(FRAME_BITS - DATA_BITS);

    mdio_state_e state, state_d;
    logic [4:0]  bit_cnt, bit_cnt_d;
    logic [31:0] sreg, sreg_d;
    logic [15:0] cap, cap_d;
    logic [15:0] rd_q, rd_d;
    logic        is_read, is_read_d;
    logic        mdc_q, mdc_d;
    logic        out_q, out_d;
    logic        oe_q, oe_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
            cap     <= '0;
            rd_q    <= '0;
            is_read <= 1'b0;
            mdc_q   <= 1'b0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            sreg    <= sreg_d;
            cap     <= cap_d;
            rd_q    <= rd_d;
            is_read <= is_read_d;
            mdc_q   <= mdc_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        sreg_d    = sreg;
        cap_d     = cap;
        rd_d      = rd_q;
        is_read_d = is_read;
        mdc_d     = mdc_q;
        out_d     = out_q;
        oe_d      = oe_q;
        case (state)
            IDLE, DONE: begin
                mdc_d = 1'b0;
                out_d = 1'b0;
                oe_d  = 1'b0;
                if (state == DONE) state_d = IDLE;
                // DONE's exit edge doubles as the first IDLE sample so frames can run back-to-back.
                if (MDIO_START) begin
                    state_d   = SHIFT_OUT;
                    sreg_d    = T_DATA;
                    bit_cnt_d = '0;
                    is_read_d = (T_DATA[29:28] == OP_READ);
                    out_d     = T_DATA[31];
                    oe_d      = 1'b1;
                end
            end
            SHIFT_OUT, READ_IN: begin
                if (!mdc_q) begin
                    mdc_d = 1'b1;
                    if (state == READ_IN && bit_cnt >= FIRST_CAP_BIT)
                        cap_d = {cap[14:0], MDIO_IN};
                end else begin
                    mdc_d = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = DONE;
                        out_d   = 1'b0;
                        oe_d    = 1'b0;
                        if (is_read) rd_d = cap;
                    end else begin
                        bit_cnt_d = bit_cnt + 5'd1;
                        sreg_d    = sreg << 1;
                        if (state == SHIFT_OUT && is_read && bit_cnt == LAST_DRIVEN_R) begin
                            state_d = READ_IN;
                            out_d   = 1'b0;
                            oe_d    = 1'b0;
                        end else if (state == SHIFT_OUT) begin
                            out_d = sreg[30];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MDC       = mdc_q;
    assign MDIO_OUT  = out_q;
    assign MDIO_OE   = oe_q;
    assign MDIO_DONE = (state == DONE);
    assign DATA_RDY  = (state == DONE) && is_read;
    assign RD_DATA   = rd_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_mdio_controller.sv
// Directed bench for mdio_controller: frame bits and read data are queued as expectations
// when a frame is launched and compared cycle by cycle as the controller produces them.
module tb_mdio_controller;
    import mdio_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_DONE;
    logic        DATA_RDY;
    logic [15:0] RD_DATA;
    mdio_state_e DBG_STATE;

    mdio_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDC        (MDC),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .MDIO_DONE  (MDIO_DONE),
        .DATA_RDY   (DATA_RDY),
        .RD_DATA    (RD_DATA),
        .DBG_STATE  (DBG_STATE)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard: {oe, out} per frame bit, and read data per read frame
    logic [1:0]  exp_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] last_rd;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mdc"},   32'(MDC),       32'd0);
        chk({tag, "_out"},   32'(MDIO_OUT),  32'd0);
        chk({tag, "_oe"},    32'(MDIO_OE),   32'd0);
        chk({tag, "_done"},  32'(MDIO_DONE), 32'd0);
        chk({tag, "_rdy"},   32'(DATA_RDY),  32'd0);
        chk({tag, "_rd"},    32'(RD_DATA),   32'h0);
        chk({tag, "_state"}, 32'(DBG_STATE), 32'(IDLE));
    endtask

    // Called at a negedge. Pushes expectations, launches the frame (unless the previous
    // frame already chained it) and checks every cycle from k to k+64.
    task automatic run_frame(input logic [31:0] f, input logic [15:0] rdata,
                             input bit pre_started, input bit chain,
                             input logic [31:0] next_f, input bit glitch, input int abort_at);
        bit          rd;
        logic [1:0]  e;
        logic [15:0] exp_rd;
        rd = (f[29:28] == 2'b10);
        for (int n = 0; n < 32; n++) begin
            if (rd && n >= 14) exp_q.push_back(2'b00);
            else               exp_q.push_back({1'b1, f[31-n]});
        end
        if (rd) rd_q.push_back(rdata);
        if (!pre_started) begin
            T_DATA     = f;
            MDIO_START = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        MDIO_START = 1'b0;
        T_DATA     = $urandom;
        for (int m = 0; m <= 64; m++) begin
            if (abort_at > 0 && m == abort_at) begin
                RESET = 1'b1;
                #1;
                chk_reset_outputs("abort");
                exp_q.delete();
                rd_q.delete();
                last_rd = 16'h0;
                repeat (2) begin
                    @(negedge CLK);
                    chk("abort_hold_done", 32'(MDIO_DONE), 32'd0);
                    chk("abort_hold_mdc",  32'(MDC),       32'd0);
                end
                RESET = 1'b0;
                return;
            end
            MDIO_START = (glitch && (m == 9 || m == 63)) || (chain && m == 64);
            T_DATA     = (chain && m == 64) ? next_f : $urandom;
            if (m % 2 == 0 && m >= 32 && m < 64) MDIO_IN = rdata[31 - m/2];
            else                                 MDIO_IN = 1'($urandom_range(0, 1));

            chk("mdc",  32'(MDC),       (m < 64) ? 32'(m % 2) : 32'd0);
            chk("done", 32'(MDIO_DONE), 32'(m == 64));
            chk("rdy",  32'(DATA_RDY),  32'(m == 64 && rd));
            if (m < 64) begin
                chk("rd_hold", 32'(RD_DATA), 32'(last_rd));
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = (m % 2 == 1) ? exp_q.pop_front() : exp_q[0];
                    chk($sformatf("bus_bit%0d", m/2), 32'({MDIO_OE, MDIO_OUT}), 32'(e));
                end
            end else begin
                chk("end_oe",    32'(MDIO_OE),   32'd0);
                chk("end_out",   32'(MDIO_OUT),  32'd0);
                chk("end_state", 32'(DBG_STATE), 32'(DONE));
                exp_rd = last_rd;
                if (rd) begin
                    if (rd_q.size() == 0) chk("rd_q_empty", 32'(rd_q.size()), 32'd1);
                    else                  exp_rd = rd_q.pop_front();
                end
                chk("rd_data", 32'(RD_DATA), 32'(exp_rd));
                last_rd = exp_rd;
            end
            if (m < 64) @(negedge CLK);
        end
        if (!chain) begin
            @(negedge CLK);
            MDIO_START = 1'b0;
            chk("post_done", 32'(MDIO_DONE), 32'd0);
            chk("post_rdy",  32'(DATA_RDY),  32'd0);
            chk("post_rd",   32'(RD_DATA),   32'(last_rd));
            repeat (3) begin
                @(negedge CLK);
                chk("idle_state", 32'(DBG_STATE), 32'(IDLE));
                chk("idle_mdc",   32'(MDC),       32'd0);
                chk("idle_oe",    32'(MDIO_OE),   32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] w1, r1, w3, r2, r3, w4, r4;
        logic [15:0] d2, d4;
        total      = 0;
        bad        = 0;
        last_rd    = 16'h0;
        RESET      = 1'b1;
        MDIO_START = 1'b0;
        T_DATA     = 32'h0;
        MDIO_IN    = 1'b0;

        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        MDIO_START = 1'b1;
        @(negedge CLK);
        chk("start_in_reset", 32'(DBG_STATE), 32'(IDLE));
        MDIO_START = 1'b0;
        RESET      = 1'b0;
        @(negedge CLK);

        w1 = {2'b01, 2'b01, 5'h03, 5'h0A, 2'b10, 16'hBEEF};
        run_frame(w1, 16'h0, 0, 0, 32'h0, 0, 0);

        r1 = {2'b01, 2'b10, 5'h03, 5'h02, 2'b11, 16'hFFFF};
        run_frame(r1, 16'hA5C3, 0, 0, 32'h0, 1, 0);

        w3 = {2'b01, 2'b11, 5'h1F, 5'h11, 2'b10, 16'h1234};
        d2 = 16'($urandom_range(0, 16'hFFFF));
        r2 = {2'b01, 2'b10, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'b11, 16'h0};
        run_frame(w3, 16'h0, 0, 1, r2, 0, 0);
        run_frame(r2, d2, 1, 0, 32'h0, 0, 0);

        r3 = {2'b01, 2'b10, 5'h07, 5'h01, 2'b11, 16'h0};
        run_frame(r3, 16'h5A5A, 0, 0, 32'h0, 0, 30);
        @(negedge CLK);
        chk_reset_outputs("after_abort");

        w4 = {2'b01, 2'b01, 5'h11, 5'h1E, 2'b10, 16'($urandom)};
        run_frame(w4, 16'h0, 0, 0, 32'h0, 0, 0);
        d4 = 16'h3C96;
        r4 = {2'b01, 2'b10, 5'h00, 5'h1F, 2'b11, 16'h0};
        run_frame(r4, d4, 0, 0, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
